// File: rtl/ttrng_pkg.sv
// Shared types and constants for the ttrng byte reader.
package ttrng_pkg;

  localparam int BYTE_W = 8;
  localparam int OVR_W  = 4;
  localparam int BCNT_W = $clog2(BYTE_W);

  // COLLECT assembles bytes; FAIL is terminal until reset.
  typedef enum logic {
    COLLECT = 1'b0,
    FAIL    = 1'b1
  } state_e;

endpackage

// File: rtl/ttrng_vn_debias.sv
// Optional von Neumann debiaser between the sample tick and the byte packer.
// Build macro TTRNG_VN_DEBIAS_EN: when defined, accepted bits come from pairs of
// consecutive tick samples (01->0, 10->1, 00/11 dropped); when undefined the
// block is a pure pass-through and has no state.
module ttrng_vn_debias (
`ifdef TTRNG_VN_DEBIAS_EN
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
`endif
  input  logic tick_i,
  input  logic sample_i,
  output logic bit_valid_o,
  output logic bit_o
);

`ifdef TTRNG_VN_DEBIAS_EN
  logic have_q, have_d;
  logic first_q, first_d;

  // Pair tracking: hold the first sample of a pair, emit on the second if they differ.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    have_d      = have_q;
    first_d     = first_q;
    bit_valid_o = 1'b0;
    bit_o       = first_q;
    if (clr_i) begin
      have_d = 1'b0;
    end else if (tick_i) begin
      if (!have_q) begin
        have_d  = 1'b1;
        first_d = sample_i;
      end else begin
        have_d      = 1'b0;
        bit_valid_o = first_q ^ sample_i;
      end
    end
  end

  // Pair register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      have_q  <= have_d;
      first_q <= first_d;
    end
  end
`else
  // Pass-through: every tick sample is an accepted bit.
  always_comb begin
    bit_valid_o = tick_i;
    bit_o       = sample_i;
  end
`endif

endmodule

// File: rtl/ttrng_byte_reader.sv
// Consumer side of the ttrng entropy path: synchronises the raw ring-oscillator
// bit, samples it every SAMPLE_DIV cycles, runs a repetition-count health test
// and packs accepted bits MSB-first into bytes offered on a valid/ack handshake.
// Build macro TTRNG_VN_DEBIAS_EN enables von Neumann debiasing of the samples.
module ttrng_byte_reader
  import ttrng_pkg::*;
#(
  parameter int SAMPLE_DIV = 4,
  parameter int REP_LIMIT  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              raw_bit,
  input  logic              ack,
  output logic [BYTE_W-1:0] number,
  output logic              valid,
  output logic              health_fail,
  output logic [OVR_W-1:0]  overrun_cnt
);

  localparam int              CNT_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [7:0]      REP_MAX = 8'(REP_LIMIT);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(BYTE_W - 1);

  logic sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] rep_q, rep_d, rep_nxt;
  logic prev_q, prev_d;
  logic [BYTE_W-2:0] shift_q, shift_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [BYTE_W-1:0] number_q, number_d;
  logic valid_q, valid_d;
  logic health_fail_q, health_fail_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  state_e state_q, state_d;

  logic sample, tick, trip, collecting;
  logic acc_valid, acc_bit;

  assign sample = sync2_q;

  // Two-flop synchroniser for the asynchronous raw bit; free-running regardless of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments only, so every flop
    // sees pre-edge values and sync2 really lags sync1 by one cycle.
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_bit;
      sync2_q <= sync1_q;
    end
  end

  // Sample tick: the counter only advances while enabled, so no tick when ena is low.
  assign tick = ena && (cnt_q == CNT_MAX);

  // Tick counter and repetition-count health test next state.
  always_comb begin
    cnt_d = cnt_q;
    if (ena) cnt_d = tick ? '0 : cnt_q + 1'b1;

    if (sample != prev_q)  rep_nxt = 8'd1;
    else if (rep_q != '1)  rep_nxt = rep_q + 8'd1;
    else                   rep_nxt = rep_q;

    rep_d  = tick ? rep_nxt : rep_q;
    prev_d = tick ? sample : prev_q;
    trip   = tick && (rep_nxt == REP_MAX);
  end

  // FSM next state: a health trip is the only way out of COLLECT.
  always_comb begin
    state_d = state_q;
    if (state_q == COLLECT && trip) state_d = FAIL;
  end

  // Bits arriving on the tripping tick are already discarded.
  assign collecting = (state_q == COLLECT) && !trip;

`ifdef TTRNG_VN_DEBIAS_EN
  logic clr_pair;
  assign clr_pair = !collecting;
`endif

  ttrng_vn_debias u_debias (
`ifdef TTRNG_VN_DEBIAS_EN
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr_pair),
`endif
    .tick_i      (tick),
    .sample_i    (sample),
    .bit_valid_o (acc_valid),
    .bit_o       (acc_bit)
  );

  // Shift register, byte load, handshake and overrun accounting.
  always_comb begin
    shift_d       = shift_q;
    bcnt_d        = bcnt_q;
    number_d      = number_q;
    valid_d       = valid_q && !ack;
    ovr_d         = ovr_q;
    health_fail_d = health_fail_q || trip;

    if (!collecting) begin
      shift_d = '0;
      bcnt_d  = '0;
    end else if (acc_valid) begin
      shift_d = {shift_q[BYTE_W-3:0], acc_bit};
      if (bcnt_q == LAST_BIT) begin
        bcnt_d = '0;
        // A byte loads if the slot is free or being consumed at this edge.
        if (!valid_q || ack) begin
          number_d = {shift_q, acc_bit};
          valid_d  = 1'b1;
        end else if (ovr_q != '1) begin
          ovr_d = ovr_q + 1'b1;
        end
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, datapath included, is reset so a reset mid-byte
    // leaves no stale partial byte or counter behind.
    if (!rst_n) begin
      cnt_q         <= '0;
      rep_q         <= '0;
      prev_q        <= 1'b0;
      shift_q       <= '0;
      bcnt_q        <= '0;
      number_q      <= '0;
      valid_q       <= 1'b0;
      health_fail_q <= 1'b0;
      ovr_q         <= '0;
      state_q       <= COLLECT;
    end else begin
      cnt_q         <= cnt_d;
      rep_q         <= rep_d;
      prev_q        <= prev_d;
      shift_q       <= shift_d;
      bcnt_q        <= bcnt_d;
      number_q      <= number_d;
      valid_q       <= valid_d;
      health_fail_q <= health_fail_d;
      ovr_q         <= ovr_d;
      state_q       <= state_d;
    end
  end

  assign number      = number_q;
  assign valid       = valid_q;
  assign health_fail = health_fail_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_ttrng_byte_reader.sv
// Self-checking bench for ttrng_byte_reader (SAMPLE_DIV=4, REP_LIMIT=32).
// Reference model works at tick granularity from the behavioural rules.
module tb_ttrng_byte_reader;

  localparam int SAMPLE_DIV = 4;
  localparam int REP_LIMIT  = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       raw_bit = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] number;
  logic       valid;
  logic       health_fail;
  logic [3:0] overrun_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  logic [13:0] got_v, exp_v;

  always #5 clk = ~clk;

  ttrng_byte_reader #(.SAMPLE_DIV(SAMPLE_DIV), .REP_LIMIT(REP_LIMIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .raw_bit     (raw_bit),
    .ack         (ack),
    .number      (number),
    .valid       (valid),
    .health_fail (health_fail),
    .overrun_cnt (overrun_cnt)
  );

  // Reference model state.
  logic [7:0] m_number, m_bits;
  logic       m_valid, m_fail, m_prev, m_have, m_first;
  logic [3:0] m_ovr;
  int         m_nbits, m_run;

  function automatic void model_reset();
    m_number = 0; m_bits = 0; m_valid = 0; m_fail = 0; m_prev = 0;
    m_have = 0; m_first = 0; m_ovr = 0; m_nbits = 0; m_run = 0;
  endfunction

  function automatic void model_tick(input logic b, input logic ack_now);
    logic accepted, abit;
    accepted = 0;
    abit = 0;
    m_run = (b != m_prev) ? 1 : m_run + 1;
    m_prev = b;
    if (ack_now) m_valid = 0;
    if (m_run == REP_LIMIT) m_fail = 1;
    if (m_fail) begin
      m_nbits = 0; m_bits = 0; m_have = 0;
      return;
    end
`ifdef TTRNG_VN_DEBIAS_EN
    if (!m_have) begin
      m_have = 1; m_first = b;
    end else begin
      m_have = 0;
      if (m_first != b) begin accepted = 1; abit = m_first; end
    end
`else
    accepted = 1;
    abit = b;
`endif
    if (accepted) begin
      m_bits = {m_bits[6:0], abit};
      m_nbits++;
      if (m_nbits == 8) begin
        m_nbits = 0;
        if (!m_valid) begin
          m_number = m_bits;
          m_valid = 1;
        end else if (m_ovr != 4'd15) begin
          m_ovr = m_ovr + 4'd1;
        end
      end
    end
  endfunction

  function automatic logic [13:0] model_vec();
    return {m_number, m_valid, m_fail, m_ovr};
  endfunction

  // One sample period: raw bit set right after the previous tick, optional ack
  // on a non-tick edge (mid) and on the tick edge itself. Starts and ends at a negedge.
  task automatic tick_step(input logic b, input logic ack_mid, input logic ack_tick);
    raw_bit = b;
    for (int i = 0; i < SAMPLE_DIV; i++) begin
      ack = (i == 1) ? ack_mid : ((i == SAMPLE_DIV - 1) ? ack_tick : 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    ack = 1'b0;
    if (ack_mid) m_valid = 0;
    model_tick(b, ack_tick);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    got_v = {number, valid, health_fail, overrun_cnt};
    tests_run++;
    if (got_v !== 14'd0) begin
      tests_failed++;
      $display("FAIL async_reset_outputs: got %h expected %h", got_v, 14'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    ena = 1'b1;
    repeat (3) @(negedge clk);
    got_v = {number, valid, health_fail, overrun_cnt};
    tests_run++;
    if (got_v !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected %h", got_v, 14'd0);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    logic [7:0] pat;
    pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      tick_step(pat[7-i], 1'b0, 1'b0);
      got_v = {number, valid, health_fail, overrun_cnt};
      exp_v = model_vec();
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL basic step %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
`ifndef TTRNG_VN_DEBIAS_EN
    tests_run++;
    if (number !== 8'hB2 || valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_byte: got number=%h valid=%b expected number=b2 valid=1", number, valid);
    end
`endif
  endtask

  task automatic test_overrun();
    logic [7:0] held;
    held = number;
    for (int i = 0; i < 8; i++) tick_step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    got_v = {number, valid, health_fail, overrun_cnt};
    exp_v = model_vec();
    tests_run++;
    if (got_v !== exp_v || number !== held) begin
      tests_failed++;
      $display("FAIL overrun_hold: got %h expected %h (held %h)", got_v, exp_v, held);
    end
    // Ack on the edge the next byte loads: load wins, valid stays high.
    for (int i = 0; i < 8; i++) tick_step(1'($urandom_range(0, 1)), 1'b0, i == 7);
    got_v = {number, valid, health_fail, overrun_cnt};
    exp_v = model_vec();
    tests_run++;
    if (got_v !== exp_v) begin
      tests_failed++;
      $display("FAIL ack_on_load: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 320; i++) begin
      tick_step(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      got_v = {number, valid, health_fail, overrun_cnt};
      exp_v = model_vec();
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL random step %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_saturate();
    tick_step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    for (int n = 0; n < 18; n++) begin
      for (int i = 0; i < 8; i++) tick_step(1'(i % 2), 1'b0, 1'b0);
      got_v = {number, valid, health_fail, overrun_cnt};
      exp_v = model_vec();
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL saturate byte %0d: got %h expected %h", n, got_v, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    // valid is high here; go three bits into a new byte, then reset.
    for (int i = 0; i < 3; i++) tick_step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      tick_step(1'(i % 2), 1'b0, 1'b0);
      got_v = {number, valid, health_fail, overrun_cnt};
      exp_v = model_vec();
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL after_reset step %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_ena();
    logic b;
    for (int i = 0; i < 4; i++) tick_step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    b = 1'($urandom_range(0, 1));
    raw_bit = b;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    ena = 1'b0;
    for (int c = 0; c < 100; c++) begin
      ack = (c == 50);
      @(negedge clk);
      if (c == 50) m_valid = 0;
    end
    ack = 1'b0;
    got_v = {number, valid, health_fail, overrun_cnt};
    exp_v = model_vec();
    tests_run++;
    if (got_v !== exp_v) begin
      tests_failed++;
      $display("FAIL ena_gap: got %h expected %h", got_v, exp_v);
    end
    ena = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    model_tick(b, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick_step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      got_v = {number, valid, health_fail, overrun_cnt};
      exp_v = model_vec();
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL ena_resume step %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_health();
    int delivered;
    int exp_delivered;
    logic prev_valid;
    pulse_reset();
    delivered = 0;
    prev_valid = 1'b0;
    for (int i = 0; i < 48; i++) begin
      tick_step(i < 32 ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      if (valid && !prev_valid) delivered++;
      prev_valid = valid;
      got_v = {number, valid, health_fail, overrun_cnt};
      exp_v = model_vec();
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL health step %0d: got %h expected %h", i, got_v, exp_v);
      end
    end
`ifdef TTRNG_VN_DEBIAS_EN
    exp_delivered = 0;
`else
    exp_delivered = 3;
`endif
    tests_run++;
    if (delivered != exp_delivered || health_fail !== 1'b1) begin
      tests_failed++;
      $display("FAIL health_bytes: got %0d bytes fail=%b expected %0d bytes fail=1",
               delivered, health_fail, exp_delivered);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_overrun();
    test_random();
    test_saturate();
    test_async_reset();
    test_ena();
    test_health();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
